// File: rtl/amber48_uart_tx_arb_if.sv
// Requester-side byte streams and UART TX byte port shared by the
// message-locked arbiter.
interface amber48_uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ*8-1:0] req_data_i;
  logic [NUM_REQ-1:0]   req_valid_i;
  logic [NUM_REQ-1:0]   req_last_i;
  logic [NUM_REQ-1:0]   req_ready_o;
  logic [7:0]           tx_data_o;
  logic                 tx_valid_o;
  logic                 tx_ready_i;
  logic [NUM_REQ-1:0]   grant_o;
  logic                 busy_o;

  modport master (
    output req_data_i,
    output req_valid_i,
    output req_last_i,
    output tx_ready_i,
    input  req_ready_o,
    input  tx_data_o,
    input  tx_valid_o,
    input  grant_o,
    input  busy_o
  );

  modport slave (
    input  req_data_i,
    input  req_valid_i,
    input  req_last_i,
    input  tx_ready_i,
    output req_ready_o,
    output tx_data_o,
    output tx_valid_o,
    output grant_o,
    output busy_o
  );
endinterface

// File: rtl/amber48_uart_tx_arb.sv
// Round-robin arbiter sharing one UART TX among byte-stream requesters;
// a grant is held until end of message, burst limit or idle timeout.
module amber48_uart_tx_arb #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 64,
  parameter int IDLE_TIMEOUT = 1024
) (
  input logic                   clk_i,
  input logic                   rst_ni,
  amber48_uart_tx_arb_if.slave  bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam int IL = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;

  localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(IL);
  localparam logic [PW-1:0] PTR_MAX    = PW'(NUM_REQ - 1);
  localparam logic          TO_EN      = (IDLE_TIMEOUT != 0);

  typedef enum logic {
    S_IDLE,
    S_LOCK
  } state_e;

  state_e               r_state;
  logic [NUM_REQ-1:0]   r_grant;
  logic [PW-1:0]        r_gidx;
  logic [PW-1:0]        r_rr_ptr;
  logic [BW-1:0]        r_burst_cnt;
  logic [IW-1:0]        r_idle_cnt;

  logic [7:0]           w_tx_data;
  logic                 w_g_valid;
  logic                 w_g_last;
  logic                 w_found;
  logic [PW-1:0]        w_pick;
  logic [PW-1:0]        w_cand;
  logic [PW-1:0]        w_next_ptr;
  logic                 w_xfer;
  logic                 w_release;

  // Granted-requester mux; all zero whenever r_grant is empty
  always_comb begin
    w_tx_data = '0;
    w_g_valid = 1'b0;
    w_g_last  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r_grant[k]) begin
        w_tx_data = bus.req_data_i[8*k +: 8];
        w_g_valid = bus.req_valid_i[k];
        w_g_last  = bus.req_last_i[k];
      end
    end
  end

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = PW'((int'(r_rr_ptr) + i) % NUM_REQ);
      if (!w_found && bus.req_valid_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_next_ptr = (r_gidx == PTR_MAX) ? '0 : r_gidx + PW'(1);
  assign w_xfer     = w_g_valid & bus.tx_ready_i;

  always_comb begin
    w_release = 1'b0;
    unique case (1'b1)
      (w_xfer & w_g_last):                    w_release = 1'b1;
      (w_xfer & (r_burst_cnt == BURST_LAST)): w_release = 1'b1;
      (TO_EN & ~w_g_valid & (r_idle_cnt == IDLE_LAST)):
                                              w_release = 1'b1;
      default:                                w_release = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_grant     <= '0;
      r_gidx      <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
      r_idle_cnt  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_LOCK;
            r_grant     <= NUM_REQ'(1) << w_pick;
            r_gidx      <= w_pick;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
          end
        end
        S_LOCK: begin
          if (w_release) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= w_next_ptr;
            r_burst_cnt <= '0;
            r_idle_cnt  <= '0;
          end else begin
            if (w_xfer)
              r_burst_cnt <= r_burst_cnt + BW'(1);
            if (w_g_valid)
              r_idle_cnt <= '0;
            else if (TO_EN)
              r_idle_cnt <= r_idle_cnt + IW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.tx_data_o   = w_tx_data;
  assign bus.tx_valid_o  = w_g_valid;
  assign bus.req_ready_o = r_grant & {NUM_REQ{bus.tx_ready_i}};
  assign bus.grant_o     = r_grant;
  assign bus.busy_o      = (r_state == S_LOCK);

endmodule

// File: tb/tb_amber48_uart_tx_arb.sv
// Bench for amber48_uart_tx_arb: one default instance and one with
// MAX_BURST=4 / IDLE_TIMEOUT=8 share the same requester stimulus.
module tb_amber48_uart_tx_arb;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N*8-1:0] r_data;
  logic [N-1:0]   r_valid;
  logic [N-1:0]   r_last;
  logic           r_txr;

  amber48_uart_tx_arb_if #(.NUM_REQ(N)) ifa ();
  amber48_uart_tx_arb_if #(.NUM_REQ(N)) ifb ();

  assign ifa.req_data_i  = r_data;
  assign ifa.req_valid_i = r_valid;
  assign ifa.req_last_i  = r_last;
  assign ifa.tx_ready_i  = r_txr;
  assign ifb.req_data_i  = r_data;
  assign ifb.req_valid_i = r_valid;
  assign ifb.req_last_i  = r_last;
  assign ifb.tx_ready_i  = r_txr;

  amber48_uart_tx_arb #(.NUM_REQ(N)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifa)
  );

  amber48_uart_tx_arb #(
    .NUM_REQ      (N),
    .MAX_BURST    (4),
    .IDLE_TIMEOUT (8)
  ) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (ifb)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0] grant;
    logic [7:0] data;
  } sb_t;

  sb_t qa[$];
  sb_t qb[$];
  bit  mon_a = 1'b0;
  bit  mon_b = 1'b0;

  always @(negedge clk) begin : mon
    sb_t e;
    if (rst_n && mon_a && ifa.tx_valid_o && r_txr) begin
      if (qa.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_a_extra: got %0h expected none",
                 ifa.tx_data_o);
      end else begin
        e = qa.pop_front();
        chk("sb_a_xfer", {ifa.grant_o, ifa.tx_data_o}, e);
      end
    end
    if (rst_n && mon_b && ifb.tx_valid_o && r_txr) begin
      if (qb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL sb_b_extra: got %0h expected none",
                 ifb.tx_data_o);
      end else begin
        e = qb.pop_front();
        chk("sb_b_xfer", {ifb.grant_o, ifb.tx_data_o}, e);
      end
    end
  end

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        txr;
    logic [3:0]  g;
    logic        txv;
    logic [7:0]  txd;
    logic [3:0]  rdy;
    logic        busy;
  } vec_t;

  vec_t tbl[11];

  task automatic chk_zero(input string nm);
    chk({nm, "_a"}, {ifa.grant_o, ifa.busy_o, ifa.tx_valid_o,
                     ifa.tx_data_o, ifa.req_ready_o}, 64'h0);
    chk({nm, "_b"}, {ifb.grant_o, ifb.busy_o, ifb.tx_valid_o,
                     ifb.tx_data_o, ifb.req_ready_o}, 64'h0);
  endtask

  task automatic do_reset();
    mon_a = 1'b0;
    mon_b = 1'b0;
    qa.delete();
    qb.delete();
    r_valid = '0;
    r_last  = '0;
    r_data  = '0;
    r_txr   = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk_zero("reset_out");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_acc(input bit use_b, input int k, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = use_b ? (ifb.req_ready_o[k] & r_valid[k])
                 : (ifa.req_ready_o[k] & r_valid[k]);
      @(posedge clk);
      #1;
    end
    chk(nm, ok, 1);
  endtask

  task automatic count_busy_b(output int bc);
    bc = 0;
    @(negedge clk);
    while (ifb.busy_o && bc < 50) begin
      bc++;
      @(negedge clk);
    end
  endtask

  logic [3:0] acc;
  int cnt[N];
  int i0, i3, gap, cyc, idles, bc;
  bit d2, d0done, bad_rdy, bad_g;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b0010, 4'b0000, 32'h0000_4100, 1'b1,
                4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[1]  = '{4'b0010, 4'b0000, 32'h0000_4100, 1'b1,
                4'b0010, 1'b1, 8'h41, 4'b0010, 1'b1};
    tbl[2]  = '{4'b0010, 4'b0000, 32'h0000_4200, 1'b1,
                4'b0010, 1'b1, 8'h42, 4'b0010, 1'b1};
    tbl[3]  = '{4'b0010, 4'b0010, 32'h0000_4300, 1'b0,
                4'b0010, 1'b1, 8'h43, 4'b0000, 1'b1};
    tbl[4]  = '{4'b0010, 4'b0010, 32'h0000_4300, 1'b1,
                4'b0010, 1'b1, 8'h43, 4'b0010, 1'b1};
    tbl[5]  = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1,
                4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[6]  = '{4'b0011, 4'b0011, 32'h0000_5150, 1'b1,
                4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[7]  = '{4'b0011, 4'b0011, 32'h0000_5150, 1'b1,
                4'b0001, 1'b1, 8'h50, 4'b0001, 1'b1};
    tbl[8]  = '{4'b0010, 4'b0010, 32'h0000_5100, 1'b1,
                4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0010, 4'b0010, 32'h0000_5100, 1'b1,
                4'b0010, 1'b1, 8'h51, 4'b0010, 1'b1};
    tbl[10] = '{4'b0000, 4'b0000, 32'h0000_0000, 1'b1,
                4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0};

    // single requester, stall, pointer advance
    do_reset();
    for (int i = 0; i < 11; i++) begin
      r_valid = tbl[i].v;
      r_last  = tbl[i].l;
      r_data  = tbl[i].d;
      r_txr   = tbl[i].txr;
      @(negedge clk);
      chk($sformatf("t1[%0d].grant", i), ifa.grant_o, tbl[i].g);
      chk($sformatf("t1[%0d].txv", i), ifa.tx_valid_o, tbl[i].txv);
      chk($sformatf("t1[%0d].txd", i), ifa.tx_data_o, tbl[i].txd);
      chk($sformatf("t1[%0d].rdy", i), ifa.req_ready_o, tbl[i].rdy);
      chk($sformatf("t1[%0d].busy", i), ifa.busy_o, tbl[i].busy);
      @(posedge clk);
      #1;
    end

    // round-robin with 1-byte messages
    do_reset();
    mon_a = 1'b1;
    r_txr = 1'b1;
    r_valid = 4'hF;
    r_last  = 4'hF;
    for (int k = 0; k < N; k++) begin
      cnt[k] = 0;
      r_data[8*k +: 8] = 8'(16*k + 1);
    end
    for (int n = 0; n < 8; n++)
      qa.push_back({4'(1 << (n % 4)), 8'(16*(n % 4) + n/4 + 1)});
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      acc = ifa.req_ready_o & r_valid;
      chk($sformatf("t2_busy[%0d]", c), ifa.busy_o, c % 2);
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k]) begin
          cnt[k]++;
          r_data[8*k +: 8] = 8'(16*k + cnt[k] + 1);
        end
      end
    end
    r_valid = '0;
    @(posedge clk);
    #1;
    chk("t2_sb_empty", qa.size(), 0);

    // message lock across a valid gap
    do_reset();
    mon_a = 1'b1;
    r_txr = 1'b1;
    for (int i = 0; i < 5; i++)
      qa.push_back({4'b0001, 8'(8'hA0 + i)});
    qa.push_back({4'b0100, 8'hC0});
    i0 = 0; gap = 0; cyc = 0;
    d2 = 1'b0; bad_rdy = 1'b0; bad_g = 1'b0;
    while (!(i0 == 5 && d2) && cyc < 200) begin
      r_valid[0] = (i0 < 5) && !(i0 == 2 && gap < 20);
      r_data[7:0] = 8'(8'hA0 + i0);
      r_last[0] = (i0 == 4);
      r_valid[2] = !d2;
      r_data[23:16] = 8'hC0;
      r_last[2] = 1'b1;
      @(negedge clk);
      acc = ifa.req_ready_o & r_valid;
      if (i0 < 5 && ifa.req_ready_o[2]) bad_rdy = 1'b1;
      if (i0 >= 1 && i0 < 5 && ifa.grant_o != 4'b0001) bad_g = 1'b1;
      @(posedge clk);
      #1;
      if (acc[0]) i0++;
      else if (i0 == 2 && !r_valid[0]) gap++;
      if (acc[2]) d2 = 1'b1;
      cyc++;
    end
    r_valid = '0;
    chk("t3_done", cyc < 200, 1);
    chk("t3_gap", gap, 20);
    chk("t3_req2_ready_low", bad_rdy, 0);
    chk("t3_grant_held", bad_g, 0);
    @(posedge clk);
    #1;
    chk("t3_sb_empty", qa.size(), 0);

    // burst limit, pointer after forced release, then timeout
    do_reset();
    mon_b = 1'b1;
    r_txr = 1'b1;
    for (int i = 0; i < 8; i++)
      qb.push_back({4'b1000, 8'(8'hD0 + i)});
    qb.push_back({4'b0001, 8'hE0});
    qb.push_back({4'b1000, 8'hD8});
    qb.push_back({4'b1000, 8'hD9});
    i3 = 0; cyc = 0; idles = 0; d0done = 1'b0;
    while (!(i3 == 10 && d0done) && cyc < 200) begin
      r_valid[3] = (i3 < 10);
      r_data[31:24] = 8'(8'hD0 + i3);
      r_last[3] = 1'b0;
      r_valid[0] = (i3 >= 6) && !d0done;
      r_data[7:0] = 8'hE0;
      r_last[0] = 1'b1;
      @(negedge clk);
      acc = ifb.req_ready_o & r_valid;
      if (i3 > 0 && !ifb.busy_o) idles++;
      @(posedge clk);
      #1;
      if (acc[3]) i3++;
      if (acc[0]) d0done = 1'b1;
      cyc++;
    end
    r_valid = '0;
    chk("t4_done", cyc < 200, 1);
    chk("t4_idle_gaps", idles, 3);
    count_busy_b(bc);
    chk("t4_timeout_cycles", bc, 8);
    chk("t4_grant_clear", ifb.grant_o, 4'b0000);
    chk("t4_sb_empty", qb.size(), 0);

    // idle timeout after a single byte
    do_reset();
    mon_b = 1'b1;
    r_txr = 1'b1;
    qb.push_back({4'b0010, 8'h77});
    r_valid = 4'b0010;
    r_last  = 4'b0000;
    r_data  = 32'h0000_7700;
    wait_acc(1'b1, 1, "t5_accept");
    r_valid = '0;
    count_busy_b(bc);
    chk("t5_timeout_cycles", bc, 8);
    @(negedge clk);
    chk("t5_busy_after", ifb.busy_o, 0);
    chk("t5_sb_empty", qb.size(), 0);

    // reset in the middle of a req2 message
    do_reset();
    r_txr = 1'b1;
    r_valid = 4'b0010;
    r_last  = 4'b0010;
    r_data  = 32'h0099_1100;
    wait_acc(1'b0, 1, "t6_req1_accept");
    r_valid = 4'b0100;
    r_last  = 4'b0000;
    cyc = 0;
    @(negedge clk);
    while (ifa.grant_o != 4'b0100 && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("t6_req2_granted", ifa.grant_o, 4'b0100);
    chk("t6_req2_xfer", ifa.tx_valid_o & ifa.req_ready_o[2], 1);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async_zero");
    r_valid = 4'b0110;
    r_last  = 4'b0110;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
    @(negedge clk);
    while (ifa.grant_o == 4'b0000 && cyc < 10) begin
      cyc++;
      @(negedge clk);
    end
    chk("t6_first_grant", ifa.grant_o, 4'b0010);
    r_valid = '0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
